multisim_client_quasi_static_pull_mc: RTL and testbench
=======================================================

MULTISIM_CLIENT_QUASI_STATIC_PULL_MC -- requirements
Module: multisim_client_quasi_static_pull_mc

Interface
REQ-001 SHALL have parameter SERVER_RUNTIME_DIRECTORY, default "../output_top", runtime directory passed to every per-channel multisim_client_pull.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, bits per channel value.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, range 1..64, number of independent pulled values.
REQ-004 SHALL have parameter POLL_INTERVAL, default 16, idle cycles between successive channel polls (0 legal).
REQ-005 SHALL have parameter POLL_TIMEOUT, default 256, max cycles waiting for data_vld in one poll (>=1).
REQ-006 SHALL have parameter STABLE_COUNT, default 1, range 1..15, consecutive identical samples required before commit.
REQ-007 SHALL have parameter RESET_VALUE, default '0, DATA_WIDTH-bit value loaded into every channel on reset.
REQ-008 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-009 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-010 SHALL have port server_name  input  string[NUM_CHANNELS]  server name per channel.
REQ-011 SHALL have port enable  input  1  permits new polls when high.
REQ-012 SHALL have port data  output  [NUM_CHANNELS][DATA_WIDTH]  committed quasi-static value per channel.
REQ-013 SHALL have port data_updated  output  [NUM_CHANNELS]  one-cycle pulse when channel value changes.
REQ-014 SHALL have port data_valid  output  [NUM_CHANNELS]  sticky, set on first commit of channel.
REQ-015 SHALL have port poll_timeout  output  [NUM_CHANNELS]  one-cycle pulse when channel poll times out.

Function
REQ-016 SHALL instantiate one multisim_client_pull per channel; data_rdy[i] driven only by this block's FSM.
REQ-017 SHALL implement FSM WAIT -> POLL -> WAIT with channel pointer sel (width clog2(NUM_CHANNELS), min 1).
REQ-018 WAIT: interval counter loaded with POLL_INTERVAL on entry, decrements each cycle; at 0 with enable=1 -> POLL; POLL_INTERVAL=0 -> POLL next cycle.
REQ-019 WAIT with enable=0: counter holds; no POLL entered.
REQ-020 POLL: data_rdy[sel]=1, all other data_rdy=0; timeout counter starts at 0, increments each cycle.
REQ-021 POLL exit on data_vld[sel]&&data_rdy[sel] (handshake) or timeout counter reaching POLL_TIMEOUT-1 without handshake; both -> WAIT, sel advances.
REQ-022 sel SHALL advance by 1, wrapping NUM_CHANNELS-1 -> 0; NUM_CHANNELS=1 keeps sel=0.
REQ-023 enable falling during POLL SHALL NOT abort the poll; it completes by handshake or timeout.
REQ-024 Timeout SHALL pulse poll_timeout[sel] for one cycle after the exit edge; channel data, candidate, match count unchanged.
REQ-025 Each channel keeps candidate register and 4-bit match count; on handshake: sample==candidate -> count+1 saturating at STABLE_COUNT; else candidate<=sample, count<=1.
REQ-026 Commit SHALL occur on the handshake edge when updated count >= STABLE_COUNT: data[sel]<=sample, data_valid[sel]<=1.
REQ-027 data_updated[sel] SHALL pulse one cycle, coincident with new data, only if committed value differs from previous data[sel] or data_valid[sel] was 0.
REQ-028 Latency: STABLE_COUNT=1 -> data visible the cycle after the handshake edge.
REQ-029 data_vld on non-selected channels SHALL be ignored (rdy=0, no handshake).

Reset
REQ-030 rst_n=0 SHALL asynchronously force: FSM=WAIT, sel=0, interval counter=POLL_INTERVAL, timeout counter=0, data=RESET_VALUE, candidates=RESET_VALUE, match counts=0, data_valid=0, data_updated=0, poll_timeout=0, all data_rdy=0.
REQ-031 Reset asserted mid-POLL SHALL drop the in-flight poll; no partial commit; after release first poll targets channel 0 after POLL_INTERVAL cycles.

Verification
REQ-032 NUM_CHANNELS=4, POLL_INTERVAL=2, STABLE_COUNT=1, servers return 0x11/0x22/0x33/0x44 -> channels commit in order 0..3, one data_updated pulse each, data_valid=4'b1111.
REQ-033 STABLE_COUNT=3, channel 0 returns 0xA,0xA,0xB,0xB,0xB -> data[0] stays RESET_VALUE until fifth sample, then 0xB with single data_updated pulse.
REQ-034 Channel 1 server silent, POLL_TIMEOUT=8 -> poll_timeout[1] pulses 8 cycles after POLL entry, data[1] unchanged, sel moves to 2.
REQ-035 Same value 0x55 re-pulled on channel 2 after commit -> no further data_updated[2] pulse, data[2]=0x55.
REQ-036 rst_n low during POLL of channel 3 with vld pending -> data[3]=RESET_VALUE, data_valid[3]=0, data_rdy all 0 immediately; next poll is channel 0.
REQ-037 enable=0 while in WAIT -> no data_rdy asserted for 100 cycles; enable=1 -> polling resumes at saved sel.

Source files
------------

// File: rtl/multisim_client_quasi_static_pull_mc.sv
// Quasi-static multi-channel puller: polls one multisim client per channel in
// round-robin order and commits a value once it has been seen STABLE_COUNT times.

// Stand-in client with no server link; it never offers data, so every poll
// times out. The multisim library provides the connected version.
module multisim_client_pull #(
   parameter string       SERVER_RUNTIME_DIRECTORY = "../output_top",
   parameter int unsigned DATA_WIDTH               = 64
) (
   input  logic                  clk,
   input  string                 server_name,
   input  logic                  data_rdy,
   output logic                  data_vld,
   output logic [DATA_WIDTH-1:0] data
);
   logic unused_inputs;

   always_comb begin
      unused_inputs = clk ^ data_rdy ^ (server_name != "") ^ (SERVER_RUNTIME_DIRECTORY != "");
      data_vld      = 1'b0;
      data          = '0;
   end
endmodule

module multisim_client_quasi_static_pull_mc #(
   parameter string                 SERVER_RUNTIME_DIRECTORY = "../output_top",
   parameter int unsigned           DATA_WIDTH               = 64,
   parameter int unsigned           NUM_CHANNELS             = 4,
   parameter int unsigned           POLL_INTERVAL            = 16,
   parameter int unsigned           POLL_TIMEOUT             = 256,
   parameter int unsigned           STABLE_COUNT             = 1,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE              = '0
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  string                                  server_name [NUM_CHANNELS],
   input  logic                                   enable,
   output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data,
   output logic [NUM_CHANNELS-1:0]                 data_updated,
   output logic [NUM_CHANNELS-1:0]                 data_valid,
   output logic [NUM_CHANNELS-1:0]                 poll_timeout
);
   localparam int unsigned      SEL_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CHANNELS - 1);
   localparam logic [31:0]      TMO_LAST = 32'(POLL_TIMEOUT - 1);
   localparam logic [31:0]      IVL_LOAD = 32'(POLL_INTERVAL);
   localparam logic [3:0]       STABLE   = 4'(STABLE_COUNT);

   typedef enum logic {ST_WAIT, ST_POLL} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [31:0]      ivl_q, ivl_d;
   logic [31:0]      tmo_q, tmo_d;

   logic [NUM_CHANNELS-1:0]                 client_rdy;
   logic [NUM_CHANNELS-1:0]                 client_vld;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] client_data;

   logic [DATA_WIDTH-1:0] cand_q  [NUM_CHANNELS];
   logic [3:0]            match_q [NUM_CHANNELS];

   logic                  handshake, timed_out, match, commit, changed;
   logic [DATA_WIDTH-1:0] sample;
   logic [3:0]            match_next;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      multisim_client_pull #(
         .SERVER_RUNTIME_DIRECTORY(SERVER_RUNTIME_DIRECTORY),
         .DATA_WIDTH              (DATA_WIDTH)
      ) u_client (
         .clk        (clk),
         .server_name(server_name[i]),
         .data_rdy   (client_rdy[i]),
         .data_vld   (client_vld[i]),
         .data       (client_data[i])
      );
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      ivl_d      = ivl_q;
      tmo_d      = tmo_q;
      client_rdy = '0;
      handshake  = 1'b0;
      timed_out  = 1'b0;
      case (state_q)
         ST_WAIT: begin
            // The interval only counts down while enabled, so a disabled WAIT holds.
            if (enable) begin
               if (ivl_q == '0) begin
                  state_d = ST_POLL;
                  tmo_d   = '0;
               end else begin
                  ivl_d = ivl_q - 32'd1;
               end
            end
         end
         ST_POLL: begin
            client_rdy[sel_q] = 1'b1;
            handshake         = client_vld[sel_q];
            timed_out         = !client_vld[sel_q] && (tmo_q == TMO_LAST);
            if (handshake || timed_out) begin
               state_d = ST_WAIT;
               ivl_d   = IVL_LOAD;
               sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
            end else begin
               tmo_d = tmo_q + 32'd1;
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_comb begin
      sample = client_data[sel_q];
      match  = (sample == cand_q[sel_q]);
      if (!match) begin
         match_next = 4'd1;
      end else if (match_q[sel_q] >= STABLE) begin
         match_next = STABLE;
      end else begin
         match_next = match_q[sel_q] + 4'd1;
      end
      commit  = handshake && (match_next >= STABLE);
      changed = !data_valid[sel_q] || (data[sel_q] != sample);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT;
         sel_q   <= '0;
         ivl_q   <= IVL_LOAD;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ivl_q   <= ivl_d;
         tmo_q   <= tmo_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data         <= {NUM_CHANNELS{RESET_VALUE}};
         data_valid   <= '0;
         data_updated <= '0;
         poll_timeout <= '0;
         for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            cand_q[i]  <= RESET_VALUE;
            match_q[i] <= '0;
         end
      end else begin
         data_updated <= '0;
         poll_timeout <= '0;
         if (handshake) begin
            cand_q[sel_q]  <= sample;
            match_q[sel_q] <= match_next;
         end
         if (commit) begin
            data[sel_q]         <= sample;
            data_valid[sel_q]   <= 1'b1;
            data_updated[sel_q] <= changed;
         end
         if (timed_out) begin
            poll_timeout[sel_q] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_multisim_client_quasi_static_pull_mc.sv
// Bench for the quasi-static puller: server responses are forced onto the
// client nets and every cycle is compared against a behavioural model.
module tb_multisim_client_quasi_static_pull_mc;
   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int IVL = 2;
   localparam int TMO = 8;
   localparam int STB = 3;
   localparam logic [DW-1:0] RST_VAL = 8'h5A;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic enable = 1'b0;
   string names [NCH];
   logic [NCH-1:0][DW-1:0] data;
   logic [NCH-1:0] data_updated, data_valid, poll_timeout;

   logic [NCH-1:0]         drv_vld;
   logic [NCH-1:0][DW-1:0] drv_data;

   int n_chk  = 0;
   int n_fail = 0;

   bit            m_poll;
   int            m_left, m_sel, m_age;
   logic [DW-1:0] m_cand [NCH];
   logic [DW-1:0] m_data [NCH];
   int            m_cnt  [NCH];
   bit            m_valid[NCH];
   bit            m_upd  [NCH];
   bit            m_to   [NCH];

   int            srv_dly[NCH];
   logic [DW-1:0] srv_val[NCH];
   logic [DW-1:0] srv_seq[$];
   int            obs_upd[NCH];
   int            obs_to [NCH];

   multisim_client_quasi_static_pull_mc #(
      .SERVER_RUNTIME_DIRECTORY("../output_top"),
      .DATA_WIDTH   (DW),
      .NUM_CHANNELS (NCH),
      .POLL_INTERVAL(IVL),
      .POLL_TIMEOUT (TMO),
      .STABLE_COUNT (STB),
      .RESET_VALUE  (RST_VAL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .server_name (names),
      .enable      (enable),
      .data        (data),
      .data_updated(data_updated),
      .data_valid  (data_valid),
      .poll_timeout(poll_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_poll = 1'b0;
      m_left = IVL;
      m_sel  = 0;
      m_age  = 0;
      for (int c = 0; c < NCH; c++) begin
         m_cand[c]  = RST_VAL;
         m_data[c]  = RST_VAL;
         m_cnt[c]   = 0;
         m_valid[c] = 1'b0;
         m_upd[c]   = 1'b0;
         m_to[c]    = 1'b0;
      end
   endtask

   task automatic check_all();
      logic [NCH-1:0][DW-1:0] ed;
      logic [NCH-1:0] ev, eu, et, er;
      er = '0;
      for (int c = 0; c < NCH; c++) begin
         ed[c] = m_data[c];
         ev[c] = m_valid[c];
         eu[c] = m_upd[c];
         et[c] = m_to[c];
      end
      if (m_poll) er[m_sel] = 1'b1;
      chk("data_rdy", 64'(dut.client_rdy), 64'(er));
      chk("data", 64'(data), 64'(ed));
      chk("data_valid", 64'(data_valid), 64'(ev));
      chk("data_updated", 64'(data_updated), 64'(eu));
      chk("poll_timeout", 64'(poll_timeout), 64'(et));
   endtask

   // Server behaviour: the polled channel answers after srv_dly cycles (negative = silent);
   // every other channel sees random vld/data noise that must be ignored.
   task automatic drive();
      for (int c = 0; c < NCH; c++) begin
         drv_vld[c]  = 1'($urandom_range(0, 1));
         drv_data[c] = DW'($urandom);
      end
      if (m_poll) begin
         if (srv_dly[m_sel] >= 0 && m_age >= srv_dly[m_sel]) begin
            drv_vld[m_sel]  = 1'b1;
            drv_data[m_sel] = (m_sel == 0 && srv_seq.size() > 0) ? srv_seq[0] : srv_val[m_sel];
         end else begin
            drv_vld[m_sel] = 1'b0;
         end
      end
      force dut.client_vld  = drv_vld;
      force dut.client_data = drv_data;
   endtask

   task automatic model_sample(input int c, input logic [DW-1:0] s);
      if (s == m_cand[c]) begin
         m_cnt[c] = (m_cnt[c] + 1 > STB) ? STB : m_cnt[c] + 1;
      end else begin
         m_cand[c] = s;
         m_cnt[c]  = 1;
      end
      if (m_cnt[c] >= STB) begin
         if (!m_valid[c] || m_data[c] != s) m_upd[c] = 1'b1;
         m_data[c]  = s;
         m_valid[c] = 1'b1;
      end
   endtask

   task automatic advance();
      bit done;
      done = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         m_upd[c] = 1'b0;
         m_to[c]  = 1'b0;
      end
      if (!m_poll) begin
         if (m_left == 0 && enable) begin
            m_poll = 1'b1;
            m_age  = 0;
         end else if (enable) begin
            m_left--;
         end
      end else if (drv_vld[m_sel]) begin
         model_sample(m_sel, drv_data[m_sel]);
         if (m_sel == 0 && srv_seq.size() > 0) void'(srv_seq.pop_front());
         done = 1'b1;
      end else if (m_age == TMO - 1) begin
         m_to[m_sel] = 1'b1;
         done = 1'b1;
      end else begin
         m_age++;
      end
      if (done) begin
         m_poll = 1'b0;
         m_left = IVL;
         m_sel  = (m_sel + 1) % NCH;
      end
   endtask

   task automatic step();
      drive();
      advance();
      @(posedge clk);
      #1;
      check_all();
      for (int c = 0; c < NCH; c++) begin
         obs_upd[c] += int'(data_updated[c]);
         obs_to[c]  += int'(poll_timeout[c]);
      end
   endtask

   task automatic clear_obs();
      for (int c = 0; c < NCH; c++) begin
         obs_upd[c] = 0;
         obs_to[c]  = 0;
      end
   endtask

   initial begin
      bit found;
      int rdy_cycles;
      logic [NCH-1:0] exp_rdy;
      names = '{"srv0", "srv1", "srv2", "srv3"};
      srv_val = '{8'h11, 8'h22, 8'h33, 8'h44};
      srv_dly = '{0, 1, 2, 0};
      model_reset();
      clear_obs();

      #12;
      check_all();
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;

      // All servers answer with fixed values: each channel commits exactly once.
      repeat (120) step();
      chk("all_valid", 64'(data_valid), 64'h0F);
      chk("values_in_order", 64'(data), 64'h44332211);
      for (int c = 0; c < NCH; c++) chk("one_update_each", 64'(obs_upd[c]), 64'd1);

      // Channel 0 needs three identical samples before the new value lands.
      clear_obs();
      srv_seq = '{8'h0A, 8'h0A, 8'h0B, 8'h0B, 8'h0B};
      srv_val[0] = 8'h0B;
      repeat (140) step();
      chk("stable_commit_ch0", 64'(data[0]), 64'h0B);
      chk("stable_single_update", 64'(obs_upd[0]), 64'd1);

      // Silent server on channel 1 times out and leaves its value alone.
      clear_obs();
      srv_dly[1] = -1;
      repeat (100) step();
      chk("silent_keeps_ch1", 64'(data[1]), 64'h22);
      chk("silent_timed_out", 64'(obs_to[1] > 0), 64'd1);

      // Re-pulling an unchanged value on channel 2 gives one update only.
      clear_obs();
      srv_dly[1] = 0;
      srv_val[2] = 8'h55;
      repeat (150) step();
      chk("repeat_value_ch2", 64'(data[2]), 64'h55);
      chk("repeat_single_update", 64'(obs_upd[2]), 64'd1);

      // Random response delays (incl. last-cycle and too-late answers), values and enable.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 19) == 0) begin
            int ch;
            ch = int'($urandom_range(0, NCH - 1));
            srv_dly[ch] = int'($urandom_range(0, TMO + 1)) - 1;
            case ($urandom_range(0, 2))
               0: srv_val[ch] = RST_VAL;
               1: srv_val[ch] = 8'h01;
               default: srv_val[ch] = 8'h02;
            endcase
         end
         if ($urandom_range(0, 29) == 0) enable = ~enable;
         step();
      end

      // Reset during a channel-3 poll with data already offered.
      enable = 1'b1;
      srv_dly[3] = 0;
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         step();
         if (m_poll && m_sel == 3 && m_age == 0) found = 1'b1;
      end
      chk("reach_ch3_poll", 64'(found), 64'd1);
      drive();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_data3", 64'(data[3]), 64'(RST_VAL));
      chk("rst_rdy_now", 64'(dut.client_rdy), 64'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all();
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (60) step();

      // Disable while waiting: no poll for 100 cycles, then resume at the saved channel.
      found = 1'b0;
      for (int k = 0; k < 50 && !found; k++) begin
         step();
         if (!m_poll) found = 1'b1;
      end
      chk("reach_wait", 64'(found), 64'd1);
      enable = 1'b0;
      rdy_cycles = 0;
      repeat (100) begin
         step();
         if (dut.client_rdy != '0) rdy_cycles++;
      end
      chk("disabled_no_rdy", 64'(rdy_cycles), 64'd0);
      exp_rdy = '0;
      exp_rdy[m_sel] = 1'b1;
      enable = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (m_poll) found = 1'b1;
      end
      chk("resume_saved_sel", 64'(dut.client_rdy), 64'(exp_rdy));
      repeat (40) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
